sp_icache_ctrl_responder: RTL and testbench

//  Cache-side endpoint of the icache control bus, directly downstream of the ctrl unit.

---
 rtl/sp_icache_ctrl_pkg.sv | 20 ++
 rtl/sp_icache_perf_cnt.sv | 23 ++
 rtl/sp_icache_ctrl_responder.sv | 173 +++++++++++++++++
 tb/tb_sp_icache_ctrl_responder.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sp_icache_ctrl_pkg.sv
// Shared types for the icache control-bus responder: FSM states, latched operation, counter width.
package sp_icache_ctrl_pkg;

  localparam int CNT_W = 32;

  typedef enum logic [2:0] {
    ST_DISABLED,
    ST_ENABLED,
    ST_DRAIN,
    ST_FLUSH,
    ST_ACK
  } ctrl_state_e;

  typedef enum logic [1:0] {
    OP_EN,
    OP_DIS,
    OP_FLUSH
  } ctrl_op_e;

endpackage

// File: rtl/sp_icache_perf_cnt.sv
// One wrapping 32-bit event counter; a synchronous clear wins over an increment in the same cycle.
module sp_icache_perf_cnt
  import sp_icache_ctrl_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             enable_i,
  input  logic             event_i,
  output logic [CNT_W-1:0] count_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_o <= '0;
    end else if (clear_i) begin
      count_o <= '0;
    end else if (enable_i && event_i) begin
      count_o <= count_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/sp_icache_ctrl_responder.sv
// Cache-side endpoint of the icache control bus: enable/disable/flush with 4-phase handshake.
// Perf counters are built only when ICACHE_CTRL_PERF_CNT_EN is defined; otherwise they read 0.
module sp_icache_ctrl_responder
  import sp_icache_ctrl_pkg::*;
#(
  parameter int NB_SETS     = 128,
  parameter int MAX_PENDING = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       ctrl_req_enable_i,
  input  logic                       ctrl_req_disable_i,
  input  logic                       flush_req_i,
  output logic                       ctrl_ack_enable_o,
  output logic                       ctrl_ack_disable_o,
  output logic                       flush_ack_o,
  output logic                       ctrl_pending_trans_o,
  input  logic                       ctrl_clear_regs_i,
  input  logic                       ctrl_enable_regs_i,
  output logic [CNT_W-1:0]           ctrl_hit_count_o,
  output logic [CNT_W-1:0]           ctrl_trans_count_o,
  output logic [CNT_W-1:0]           ctrl_miss_count_o,
  input  logic                       fetch_req_i,
  input  logic                       fetch_gnt_i,
  input  logic                       hit_i,
  input  logic                       miss_i,
  input  logic                       refill_req_i,
  input  logic                       refill_rvalid_i,
  output logic                       fetch_stall_o,
  output logic                       cache_enable_o,
  output logic                       tag_clr_o,
  output logic [$clog2(NB_SETS)-1:0] tag_clr_idx_o
);

  localparam int IDX_W  = $clog2(NB_SETS);
  localparam int PEND_W = $clog2(MAX_PENDING + 1);

  ctrl_state_e       state_q, state_d;
  ctrl_op_e          op_q, op_d;
  logic              cache_en_q;
  logic [IDX_W-1:0]  idx_q;
  logic [PEND_W-1:0] pending_q;
  logic              any_req, drain_done, last_idx, op_req;

  assign any_req    = ctrl_req_enable_i | ctrl_req_disable_i | flush_req_i;
  // A refill issued in the very cycle we would leave DRAIN must still be waited for.
  assign drain_done = (pending_q == '0) && !refill_req_i;
  assign last_idx   = (idx_q == IDX_W'(NB_SETS - 1));

  always_comb begin
    op_req = ctrl_req_enable_i;
    case (op_q)
      OP_DIS:   op_req = ctrl_req_disable_i;
      OP_FLUSH: op_req = flush_req_i;
      default:  ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    case (state_q)
      ST_DISABLED, ST_ENABLED: begin
        if (any_req) begin
          state_d = ST_DRAIN;
          if (ctrl_req_disable_i)  op_d = OP_DIS;
          else if (flush_req_i)    op_d = OP_FLUSH;
          else                     op_d = OP_EN;
        end
      end
      ST_DRAIN: begin
        if (drain_done) state_d = (op_q == OP_FLUSH) ? ST_FLUSH : ST_ACK;
      end
      ST_FLUSH: begin
        if (last_idx) state_d = ST_ACK;
      end
      ST_ACK: begin
        if (!op_req) state_d = cache_en_q ? ST_ENABLED : ST_DISABLED;
      end
      default: state_d = ST_DISABLED;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_DISABLED;
      op_q    <= OP_EN;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  // Mode only changes once outstanding refills have drained; a flush leaves it as it was.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cache_en_q <= 1'b0;
    end else if (state_q == ST_DRAIN && drain_done && op_q != OP_FLUSH) begin
      cache_en_q <= (op_q == OP_EN);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q <= '0;
    end else if (state_q == ST_FLUSH && !last_idx) begin
      idx_q <= idx_q + IDX_W'(1);
    end else begin
      idx_q <= '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else if (refill_req_i && !refill_rvalid_i) begin
      pending_q <= pending_q + PEND_W'(1);
    end else if (!refill_req_i && refill_rvalid_i) begin
      pending_q <= pending_q - PEND_W'(1);
    end
  end

  pending_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(refill_req_i && !refill_rvalid_i && pending_q == PEND_W'(MAX_PENDING)));
  pending_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(refill_rvalid_i && !refill_req_i && pending_q == '0));

  assign ctrl_ack_enable_o    = (state_q == ST_ACK) && (op_q == OP_EN);
  assign ctrl_ack_disable_o   = (state_q == ST_ACK) && (op_q == OP_DIS);
  assign flush_ack_o          = (state_q == ST_ACK) && (op_q == OP_FLUSH);
  assign ctrl_pending_trans_o = (pending_q != '0);
  assign fetch_stall_o        = (state_q == ST_DRAIN) || (state_q == ST_FLUSH) || (state_q == ST_ACK);
  assign cache_enable_o       = cache_en_q;
  assign tag_clr_o            = (state_q == ST_FLUSH);
  assign tag_clr_idx_o        = idx_q;

`ifdef ICACHE_CTRL_PERF_CNT_EN
  sp_icache_perf_cnt u_hit_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (ctrl_clear_regs_i),
    .enable_i (ctrl_enable_regs_i),
    .event_i  (hit_i),
    .count_o  (ctrl_hit_count_o)
  );

  sp_icache_perf_cnt u_trans_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (ctrl_clear_regs_i),
    .enable_i (ctrl_enable_regs_i),
    .event_i  (fetch_req_i & fetch_gnt_i),
    .count_o  (ctrl_trans_count_o)
  );

  sp_icache_perf_cnt u_miss_cnt (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (ctrl_clear_regs_i),
    .enable_i (ctrl_enable_regs_i),
    .event_i  (miss_i),
    .count_o  (ctrl_miss_count_o)
  );
`else
  logic unused_perf_inputs;
  assign unused_perf_inputs = ^{ctrl_clear_regs_i, ctrl_enable_regs_i, fetch_req_i,
                                fetch_gnt_i, hit_i, miss_i};
  assign ctrl_hit_count_o   = '0;
  assign ctrl_trans_count_o = '0;
  assign ctrl_miss_count_o  = '0;
`endif

endmodule

// File: tb/tb_sp_icache_ctrl_responder.sv
// Self-checking bench for sp_icache_ctrl_responder (NB_SETS=8), random refill traffic against a
// transaction-level model; counter checks follow ICACHE_CTRL_PERF_CNT_EN.
module tb_sp_icache_ctrl_responder;

  localparam int NB       = 8;
  localparam int MAX_PEND = 4;
`ifdef ICACHE_CTRL_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_en, req_dis, req_fl;
  logic        ack_en, ack_dis, ack_fl;
  logic        pend_o;
  logic        clr_regs, en_regs;
  logic [31:0] hit_cnt, trans_cnt, miss_cnt;
  logic        fetch_req, fetch_gnt, hit, miss;
  logic        refill_req, refill_rvalid;
  logic        stall, cache_en, tag_clr;
  logic [2:0]  tag_idx;
  logic [2:0]  acks;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          lat_last = 0;
  int          pend_m = 0;
  logic        en_m = 1'b0;
  logic [31:0] hit_m = '0, trans_m = '0, miss_m = '0;

  assign acks = {ack_en, ack_dis, ack_fl};

  always #5 clk = ~clk;

  sp_icache_ctrl_responder #(.NB_SETS(NB), .MAX_PENDING(MAX_PEND)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .ctrl_req_enable_i    (req_en),
    .ctrl_req_disable_i   (req_dis),
    .flush_req_i          (req_fl),
    .ctrl_ack_enable_o    (ack_en),
    .ctrl_ack_disable_o   (ack_dis),
    .flush_ack_o          (ack_fl),
    .ctrl_pending_trans_o (pend_o),
    .ctrl_clear_regs_i    (clr_regs),
    .ctrl_enable_regs_i   (en_regs),
    .ctrl_hit_count_o     (hit_cnt),
    .ctrl_trans_count_o   (trans_cnt),
    .ctrl_miss_count_o    (miss_cnt),
    .fetch_req_i          (fetch_req),
    .fetch_gnt_i          (fetch_gnt),
    .hit_i                (hit),
    .miss_i               (miss),
    .refill_req_i         (refill_req),
    .refill_rvalid_i      (refill_rvalid),
    .fetch_stall_o        (stall),
    .cache_enable_o       (cache_en),
    .tag_clr_o            (tag_clr),
    .tag_clr_idx_o        (tag_idx)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drives one cycle of refill traffic, lets the edge happen, and advances the pending model.
  task automatic applyStimulus(input logic rr, input logic rv);
    refill_req    = rr;
    refill_rvalid = rv;
    @(posedge clk);
    pend_m = pend_m + int'(rr) - int'(rv);
    cyc++;
    #1;
  endtask

  task automatic checkIdle();
    checkOutput("idle_stall", stall, 0);
    checkOutput("idle_acks", acks, 0);
    checkOutput("idle_tag_clr", tag_clr, 0);
    checkOutput("idle_tag_idx", tag_idx, 0);
    checkOutput("idle_pending", pend_o, pend_m != 0);
    checkOutput("idle_cache_en", cache_en, en_m);
  endtask

  task automatic idleTraffic(input int n);
    logic rr, rv;
    for (int i = 0; i < n; i++) begin
      rr = (pend_m < MAX_PEND) && ($urandom_range(0, 1) == 1);
      rv = (pend_m > 0) && ($urandom_range(0, 1) == 1);
      applyStimulus(rr, rv);
      checkOutput("traffic_pending", pend_o, pend_m != 0);
      checkOutput("traffic_stall", stall, 0);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {acks, pend_o, stall, cache_en, tag_clr, tag_idx}, 0);
    checkOutput({tag, "_hit"}, hit_cnt, 0);
    checkOutput({tag, "_trans"}, trans_cnt, 0);
    checkOutput({tag, "_miss"}, miss_cnt, 0);
  endtask

  // One full handshake. Held requests not selected by priority stay high afterwards.
  task automatic serveReq(input logic e, input logic d, input logic f, input bit directed,
                          input logic [63:0] rv_mask, input int abort_idx);
    int         op, start, extra;
    bit         done;
    logic       rr, rv, exit_now;
    logic [2:0] exp_ack;
    op      = d ? 1 : (f ? 2 : 0);
    exp_ack = (op == 0) ? 3'b100 : ((op == 1) ? 3'b010 : 3'b001);
    start   = cyc;
    req_en  = e;
    req_dis = d;
    req_fl  = f;
    rv = directed ? rv_mask[0] : ((pend_m > 0) && ($urandom_range(0, 1) == 1));
    applyStimulus(1'b0, rv);
    checkOutput("req_stall", stall, 1);
    checkOutput("req_acks", acks, 0);
    extra = 0;
    done  = 1'b0;
    for (int k = 1; k < 64 && !done; k++) begin
      if (directed) begin
        rr = 1'b0;
        rv = rv_mask[k];
      end else begin
        rr = (extra < 2) && (pend_m < MAX_PEND) && ($urandom_range(0, 3) == 0);
        rv = (pend_m > 0) && ($urandom_range(0, 1) == 1);
      end
      exit_now = (pend_m == 0) && !rr;
      if (rr) extra++;
      applyStimulus(rr, rv);
      if (exit_now) begin
        done = 1'b1;
      end else begin
        checkOutput("drain_stall", stall, 1);
        checkOutput("drain_acks", acks, 0);
        checkOutput("drain_pending", pend_o, pend_m != 0);
        checkOutput("drain_cache_en", cache_en, en_m);
      end
    end
    checkOutput("drain_finished", done, 1);
    if (!done) return;
    if (op == 2) begin
      for (int i = 0; i < NB; i++) begin
        checkOutput("flush_tag_clr", tag_clr, 1);
        checkOutput("flush_idx", tag_idx, i);
        checkOutput("flush_ack_early", acks, 0);
        checkOutput("flush_cache_en", cache_en, en_m);
        if (i == abort_idx) begin
          rst = 1'b1;
          #1;
          pend_m  = 0;
          en_m    = 1'b0;
          hit_m   = '0;
          trans_m = '0;
          miss_m  = '0;
          checkAllZero("abort_reset");
          req_en  = 1'b0;
          req_dis = 1'b0;
          req_fl  = 1'b0;
          @(posedge clk);
          #1;
          rst = 1'b0;
          applyStimulus(1'b0, 1'b0);
          checkIdle();
          return;
        end
        applyStimulus(1'b0, 1'b0);
      end
    end else begin
      en_m = (op == 0);
    end
    lat_last = cyc - start;
    checkOutput("ack_value", acks, exp_ack);
    checkOutput("ack_stall", stall, 1);
    checkOutput("ack_tag_clr", tag_clr, 0);
    checkOutput("ack_cache_en", cache_en, en_m);
    for (int h = $urandom_range(0, 3); h > 0; h--) begin
      applyStimulus(1'b0, 1'b0);
      checkOutput("ack_hold", acks, exp_ack);
    end
    if (op == 0)      req_en  = 1'b0;
    else if (op == 1) req_dis = 1'b0;
    else              req_fl  = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkOutput("ack_release", acks, 0);
    checkOutput("release_stall", stall, 0);
    checkOutput("release_cache_en", cache_en, en_m);
  endtask

  task automatic perfStep(input logic h, input logic m, input logic fr, input logic fg,
                          input logic clr, input logic en);
    hit       = h;
    miss      = m;
    fetch_req = fr;
    fetch_gnt = fg;
    clr_regs  = clr;
    en_regs   = en;
    if (clr) begin
      hit_m   = '0;
      trans_m = '0;
      miss_m  = '0;
    end else if (en) begin
      hit_m   = hit_m + 32'(h);
      miss_m  = miss_m + 32'(m);
      trans_m = trans_m + 32'(fr & fg);
    end
    applyStimulus(1'b0, 1'b0);
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_hit"}, hit_cnt, PERF_ON ? hit_m : 32'h0);
    checkOutput({tag, "_trans"}, trans_cnt, PERF_ON ? trans_m : 32'h0);
    checkOutput({tag, "_miss"}, miss_cnt, PERF_ON ? miss_m : 32'h0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic e, d, f;
    rst = 1'b1;
    {req_en, req_dis, req_fl, clr_regs, en_regs} = '0;
    {fetch_req, fetch_gnt, hit, miss, refill_req, refill_rvalid} = '0;
    repeat (2) @(posedge clk);
    #1;
    checkAllZero("reset");
    rst = 1'b0;
    applyStimulus(1'b0, 1'b0);
    checkIdle();

    serveReq(1'b1, 1'b0, 1'b0, 1'b1, 64'h0, -1);
    checkOutput("enable_latency", lat_last, 2);
    checkOutput("enabled_after_ack", cache_en, 1);

    applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    checkOutput("two_refills_pending", pend_o, 1);
    serveReq(1'b0, 1'b1, 1'b0, 1'b1, 64'h28, -1);
    checkOutput("disable_latency", lat_last, 7);
    checkOutput("disabled_after_ack", cache_en, 0);

    idleTraffic(4);
    serveReq(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, -1);
    idleTraffic(3);
    serveReq(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, -1);
    serveReq(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, -1);
    serveReq(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, -1);

    serveReq(1'b1, 1'b1, 1'b1, 1'b0, 64'h0, -1);
    serveReq(1'b1, 1'b0, 1'b1, 1'b0, 64'h0, -1);
    serveReq(1'b1, 1'b0, 1'b0, 1'b0, 64'h0, -1);
    checkIdle();

    for (int r = 0; r < 10; r++) begin
      idleTraffic($urandom_range(0, 6));
      do begin
        e = 1'($urandom_range(0, 1));
        d = 1'($urandom_range(0, 1));
        f = 1'($urandom_range(0, 1));
      end while (!(e | d | f));
      serveReq(e, d, f, 1'b0, 64'h0, -1);
      {req_en, req_dis, req_fl} = '0;
    end

    while (pend_m > 0) applyStimulus(1'b0, 1'b1);
    serveReq(1'b0, 1'b0, 1'b1, 1'b0, 64'h0, 3);
    serveReq(1'b1, 1'b0, 1'b0, 1'b1, 64'h0, -1);
    checkOutput("enable_after_abort_latency", lat_last, 2);

    for (int i = 0; i < 30; i++) begin
      perfStep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'b0, $urandom_range(0, 3) != 0);
      checkCounters("perf_random");
    end
    perfStep(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkCounters("perf_cleared");
    for (int i = 0; i < 5; i++) perfStep(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("five_hits", hit_cnt, PERF_ON ? 32'd5 : 32'd0);
    checkCounters("perf_five");
    perfStep(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("clear_beats_hit", hit_cnt, 0);
    perfStep(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkCounters("perf_disabled");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
